im_loader: RTL and testbench
============================

Name: im_loader

Overview:
- Writer-side companion to the instruction memory. It accepts a byte stream, for example from a UART receiver or a debug port.
- It packs each group of 4 bytes into a big-endian 32-bit word and issues single-cycle word writes to the instruction memory write port, indexed by word address addr[12:2].
- It is used to load code or handler images at run time instead of preloading them from files.
- It runs in the CPU clock domain and owns the memory write port while busy.

Parameters:
- AW, 11, word address width (covers 2048 words, byte address bits 12:2).
- CW, 12, word count width (max 4095 words per transfer).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a transfer; sampled only in IDLE.
- base_addr  in  AW  first word address (byte address bits 12:2), sampled with start.
- word_cnt  in  CW  number of words to load, sampled with start.
- in_valid  in  1  byte stream valid.
- in_data  in  8  byte stream data.
- in_ready  out  1  loader can accept a byte.
- we  out  1  memory write strobe, one cycle per word.
- waddr  out  AW  memory word address for the write.
- wdata  out  32  memory write data.
- busy  out  1  high from the accepted start until the done cycle, inclusive.
- done  out  1  single-cycle pulse at the end of a transfer.
- err  out  1  checksum error flag (constant 0 when the feature is off).

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE. Byte index and word counter are cleared. Any partial word is discarded.
  - All outputs are 0: in_ready, we, waddr, wdata, busy, done, err.
  - Reset mid-transfer aborts the transfer with no further writes.
- States: IDLE, LOAD, CKSUM (feature only), DONE.
- IDLE:
  - in_ready=0.
  - start=1 latches base_addr into the address pointer and word_cnt into the remaining count, sets busy=1, and clears err.
  - The next state is LOAD if word_cnt is non-zero. If word_cnt=0 the next state is DONE, with no writes.
- LOAD:
  - in_ready=1.
  - A byte is accepted on a cycle with in_valid & in_ready.
  - Bytes fill the word MSB first: byte0 goes to bits [31:24] and byte3 to bits [7:0]. A 2-bit byte index increments per accepted byte.
  - On acceptance of byte3, in the following cycle:
    - we=1, wdata holds the assembled word, waddr holds the current pointer (1-cycle write latency).
    - The pointer then increments modulo 2^AW, so 0x7FF wraps to 0x000.
    - The remaining count decrements.
  - On the fourth byte of the last word, the next state is DONE, or CKSUM when the feature is on.
  - A back-to-back stream (in_valid held high) is sustained at 1 byte/cycle. The we of word N may coincide with the acceptance of byte0 of word N+1.
  - in_valid low stalls the transfer indefinitely with no timeout. The partial word is held.
- DONE:
  - Lasts one cycle: done=1, busy=1, in_ready=0. Next state is IDLE, where busy=0.
  - The final we occurs in the same cycle as done.
- start asserted while busy is ignored, with no effect on the state or the latched parameters.
- we, waddr and wdata are registered. waddr and wdata keep their last values when we=0.
- Bytes presented in IDLE or DONE are not accepted (in_ready=0).

Optional Feature:
- Macro: IM_LOADER_CKSUM_EN.
- Defined:
  - After the last data byte, the FSM enters CKSUM with in_ready=1 and accepts exactly one extra byte.
  - The running XOR of all data bytes is cleared at start.
  - If the extra byte differs from the running XOR, err=1 from the DONE cycle until the next accepted start or reset.
  - Words already written are not rolled back.
  - With word_cnt=0, no checksum byte is expected and err=0.
- Not defined:
  - No CKSUM state and no XOR register; err is tied to 0.
  - The FSM goes LOAD to DONE directly after the last data byte.

Test Plan:
1. Single word:
   - Stimulus: start with base_addr=0x400, word_cnt=1; bytes 0x3C,0x08,0x10,0x01 back-to-back.
   - Required: the cycle after the 4th byte has we=1, waddr=0x400, wdata=0x3C081001, done=1 in the same cycle; busy drops the next cycle.
2. Burst with stalls:
   - Stimulus: word_cnt=3 from 0x418; in_valid toggled randomly.
   - Required: exactly 3 we pulses, at addresses 0x418, 0x419 and 0x41A, with correct words; no writes during stalls.
3. Wrap-around:
   - Stimulus: base_addr=0x7FF, word_cnt=2.
   - Required: writes at 0x7FF then 0x000.
4. Zero count and start while busy:
   - Stimulus: word_cnt=0.
   - Required: done one cycle after start, no we.
   - Stimulus: start pulsed mid-transfer with a different base_addr.
   - Required: ignored; addresses continue from the original base.
5. Reset mid-word:
   - Stimulus: assert rst_n=0 asynchronously after 2 bytes of a word.
   - Required: all outputs 0 immediately, no we.
   - Stimulus: a new transfer after release.
   - Required: its first word is assembled from fresh bytes only.
6. (IM_LOADER_CKSUM_EN)
   - Stimulus: word_cnt=1 with bytes 0x12,0x34,0x56,0x78 and checksum 0x08.
   - Required: err=0.
   - Stimulus: the same transfer repeated with checksum 0x09.
   - Required: err=1 at done; the word is still written at its address.

Source files
------------

// File: rtl/im_loader.sv
// Byte-stream instruction-memory loader: packs 4 bytes MSB-first into a word and writes it.
// Optional trailing XOR checksum byte enabled by defining IM_LOADER_CKSUM_EN.
module im_loader #(
    parameter int AW = 11,
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [CW-1:0] word_cnt,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [31:0]   wdata,
    output logic          busy,
    output logic          done,
    output logic          err
);

`ifdef IM_LOADER_CKSUM_EN
    typedef enum logic [1:0] {IDLE, LOAD, CKSUM, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

    state_t        state, state_nxt;
    logic [AW-1:0] ptr;
    logic [CW-1:0] remaining;
    logic [1:0]    byte_idx;
    logic [23:0]   word_p0;
    logic          accept;
    logic          load_byte;
    logic          last_byte;
    logic          last_word;

    function automatic logic [31:0] pack_word(input logic [23:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

    assign accept    = in_valid & in_ready;
    assign load_byte = accept && (state == LOAD);
    assign last_byte = load_byte && (byte_idx == 2'd3);
    assign last_word = (remaining == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = (word_cnt == '0) ? DONE : LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (last_byte && last_word) begin
`ifdef IM_LOADER_CKSUM_EN
                    state_nxt = CKSUM;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef IM_LOADER_CKSUM_EN
            CKSUM: begin
                in_ready = 1'b1;
                if (accept) state_nxt = DONE;
            end
`endif
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Control and write port: one registered write per completed word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            remaining <= '0;
            byte_idx  <= '0;
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
        end else begin
            we <= 1'b0;
            if (state == IDLE && start) begin
                ptr       <= base_addr;
                remaining <= word_cnt;
                byte_idx  <= '0;
            end else if (load_byte) begin
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                    we        <= 1'b1;
                    waddr     <= ptr;
                    wdata     <= pack_word(word_p0, in_data);
                    ptr       <= ptr + AW'(1);
                    remaining <= remaining - CW'(1);
                end
            end
        end
    end

    // Partial-word shift register; old bytes are shifted out, so no reset is needed
    always_ff @(posedge clk) begin
        if (load_byte && byte_idx != 2'd3) word_p0 <= {word_p0[15:0], in_data};
    end

`ifdef IM_LOADER_CKSUM_EN
    logic [7:0] xor_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_acc <= '0;
            err     <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                xor_acc <= '0;
                err     <= 1'b0;
            end else if (load_byte) begin
                xor_acc <= xor_acc ^ in_data;
            end else if (state == CKSUM && accept) begin
                err <= (in_data != xor_acc);
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader with a write scoreboard checked by a negedge monitor.
module tb_im_loader;
    localparam int AW = 11;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] word_cnt;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic          busy;
    logic          done;
    logic          err;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  wr_cnt = 0;

    im_loader #(.AW(AW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_cnt(word_cnt), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n === 1'b1 && we === 1'b1) begin
            wr_cnt++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_we: got addr %h data %h expected no write", waddr, wdata);
            end
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(waddr), 32'(e.a));
                chk("wr_data", wdata, e.d);
            end
        end
    end

    task automatic start_xfer(input logic [AW-1:0] a, input logic [CW-1:0] n);
        start = 1'b1; base_addr = a; word_cnt = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        in_valid = 1'b1; in_data = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        if (n >= 20) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic send_word(input logic [AW-1:0] a, input logic [31:0] d, input bit gaps,
                             inout logic [7:0] x);
        wr_t e;
        e.a = a; e.d = d;
        exp_q.push_back(e);
        for (int i = 3; i >= 0; i--) begin
            send_byte(d[i*8 +: 8], gaps);
            x = x ^ d[i*8 +: 8];
        end
    endtask

    task automatic send_cksum(input logic [7:0] x);
`ifdef IM_LOADER_CKSUM_EN
        send_byte(x, 1'b0);
`else
        x = x;
`endif
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        chk("idle_reached", 32'(busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [7:0] x;
        int         w0;

        rst_n = 1'b0; start = 1'b0; base_addr = '0; word_cnt = '0;
        in_valid = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_we",       32'(we),       0);
        chk("rst_waddr",    32'(waddr),    0);
        chk("rst_wdata",    wdata,         0);
        chk("rst_busy",     32'(busy),     0);
        chk("rst_done",     32'(done),     0);
        chk("rst_err",      32'(err),      0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single word, back-to-back
        in_valid = 1'b1; in_data = 8'hEE;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        start_xfer(11'h400, 12'd1);
        x = '0;
        send_word(11'h400, 32'h3C081001, 1'b0, x);
        in_valid = 1'b0;
`ifndef IM_LOADER_CKSUM_EN
        @(negedge clk);
        chk("t1_we",    32'(we),    1);
        chk("t1_waddr", 32'(waddr), 32'h400);
        chk("t1_wdata", wdata,      32'h3C081001);
        chk("t1_done",  32'(done),  1);
        chk("t1_busy",  32'(busy),  1);
        @(negedge clk);
        chk("t1_busy_drop", 32'(busy), 0);
        chk("t1_done_drop", 32'(done), 0);
        chk("t1_hold_data", wdata, 32'h3C081001);
        @(posedge clk); #1;
`else
        send_cksum(x);
        wait_idle();
`endif

        // Burst with random stalls
        w0 = wr_cnt;
        start_xfer(11'h418, 12'd3);
        x = '0;
        send_word(11'h418, 32'hDEADBEEF, 1'b1, x);
        send_word(11'h419, 32'h01234567, 1'b1, x);
        send_word(11'h41A, 32'h89ABCDEF, 1'b1, x);
        send_cksum(x);
        wait_idle();
        chk("t2_wr_count", 32'(wr_cnt - w0), 3);

        // Address wrap
        start_xfer(11'h7FF, 12'd2);
        x = '0;
        send_word(11'h7FF, 32'hA5A5_0001, 1'b0, x);
        send_word(11'h000, 32'h5A5A_0002, 1'b0, x);
        send_cksum(x);
        wait_idle();

        // Zero count
        w0 = wr_cnt;
        start_xfer(11'h123, 12'd0);
        @(negedge clk);
        chk("t4_zero_done",     32'(done),     1);
        chk("t4_zero_busy",     32'(busy),     1);
        chk("t4_zero_in_ready", 32'(in_ready), 0);
        chk("t4_zero_err",      32'(err),      0);
        @(negedge clk);
        chk("t4_zero_idle", 32'(busy), 0);
        chk("t4_zero_no_we", 32'(wr_cnt - w0), 0);
        @(posedge clk); #1;

        // Start while busy is ignored
        w0 = wr_cnt;
        start_xfer(11'h100, 12'd2);
        x = '0;
        exp_q.push_back('{a: 11'h100, d: 32'hCAFEF00D});
        send_byte(8'hCA, 1'b0); send_byte(8'hFE, 1'b0);
        in_valid = 1'b0;
        start_xfer(11'h200, 12'd5);
        send_byte(8'hF0, 1'b0); send_byte(8'h0D, 1'b0);
        x = 8'hCA ^ 8'hFE ^ 8'hF0 ^ 8'h0D;
        send_word(11'h101, 32'h11112222, 1'b0, x);
        send_cksum(x);
        wait_idle();
        chk("t4_busy_start_wr", 32'(wr_cnt - w0), 2);

        // Async reset mid-word
        w0 = wr_cnt;
        start_xfer(11'h050, 12'd1);
        send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_in_ready", 32'(in_ready), 0);
        chk("t5_busy",     32'(busy),     0);
        chk("t5_we",       32'(we),       0);
        chk("t5_waddr",    32'(waddr),    0);
        chk("t5_wdata",    wdata,         0);
        chk("t5_done",     32'(done),     0);
        chk("t5_err",      32'(err),      0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t5_no_we", 32'(wr_cnt - w0), 0);
        start_xfer(11'h060, 12'd1);
        x = '0;
        send_word(11'h060, 32'h11223344, 1'b0, x);
        send_cksum(x);
        wait_idle();

`ifdef IM_LOADER_CKSUM_EN
        // Checksum good then bad
        start_xfer(11'h010, 12'd1);
        x = '0;
        send_word(11'h010, 32'h12345678, 1'b0, x);
        send_byte(8'h08, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_good_done", 32'(done), 1);
        chk("t6_good_err",  32'(err),  0);
        @(posedge clk); #1;
        start_xfer(11'h010, 12'd1);
        x = '0;
        send_word(11'h010, 32'h12345678, 1'b0, x);
        send_byte(8'h09, 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("t6_bad_done", 32'(done), 1);
        chk("t6_bad_err",  32'(err),  1);
        @(negedge clk);
        chk("t6_err_hold", 32'(err), 1);
        @(posedge clk); #1;
        start_xfer(11'h020, 12'd0);
        @(negedge clk);
        chk("t6_err_clear", 32'(err), 0);
        @(posedge clk); #1;
`else
        chk("err_tied_low", 32'(err), 0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
